// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the processor-to-memory bus arbiter.
`define MEM_ARB_OWNER_RESET OWN_DCACHE

package mem_bus_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_TAG_W  = 4;
  localparam int unsigned MEM_CMD_W  = 2;
  localparam int unsigned OUTST_W    = 5;

  typedef enum logic [MEM_CMD_W-1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    BUS_COMMAND            command;
  } MEM_REQ_t;

  typedef enum logic {
    OWN_DCACHE = 1'b0,
    OWN_ICACHE = 1'b1
  } ARB_OWNER_e;

endpackage

// File: rtl/mem_bus_arbiter_owner_table.sv
// Tag ownership register file: write on load accept, clear on completion, registered popcount.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MEM_TAG_W-1:0] wr_tag,
  input  ARB_OWNER_e           wr_owner,
  input  logic                 cl_en,
  input  logic [MEM_TAG_W-1:0] cl_tag,
  output logic                 lookup_valid_c,
  output ARB_OWNER_e           lookup_owner_c,
  output logic [OUTST_W-1:0]   outstanding
);

  logic [NUM_TAGS-1:0] valid_q;
  logic [NUM_TAGS-1:0] valid_nxt;
  logic [NUM_TAGS-1:0] owner_q;
  logic [NUM_TAGS-1:0] owner_nxt;
  logic [OUTST_W-1:0]  count_nxt;

  // Lookup sees the table as it stood before this edge's update.
  always_comb begin
    lookup_valid_c = valid_q[cl_tag];
    lookup_owner_c = ARB_OWNER_e'(owner_q[cl_tag]);
  end

  // Completion clears first so a same-tag accept overwrites it.
  always_comb begin
    valid_nxt = valid_q;
    owner_nxt = owner_q;
    if (cl_en && (cl_tag != '0)) begin
      valid_nxt[cl_tag] = 1'b0;
    end
    if (wr_en && (wr_tag != '0)) begin
      valid_nxt[wr_tag] = 1'b1;
      owner_nxt[wr_tag] = wr_owner;
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      count_nxt = count_nxt + OUTST_W'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q     <= '0;
      owner_q     <= '0;
      outstanding <= '0;
    end else begin
      valid_q     <= valid_nxt;
      owner_q     <= owner_nxt;
      outstanding <= count_nxt;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory port between Dcache MSHR and Icache, and steers
// responses and completions back to the requester that owns each tag.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned NUM_TAGS     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [MEM_ADDR_W-1:0] d2arb_addr,
  input  logic [MEM_DATA_W-1:0] d2arb_data,
  input  logic [MEM_CMD_W-1:0]  d2arb_command,
  input  logic [MEM_ADDR_W-1:0] i2arb_addr,
  input  logic [MEM_DATA_W-1:0] i2arb_data,
  input  logic [MEM_CMD_W-1:0]  i2arb_command,
  output logic [MEM_ADDR_W-1:0] proc2mem_addr,
  output logic [MEM_DATA_W-1:0] proc2mem_data,
  output logic [MEM_CMD_W-1:0]  proc2mem_command,
  input  logic [MEM_TAG_W-1:0]  mem2proc_response,
  input  logic [MEM_TAG_W-1:0]  mem2proc_tag,
  input  logic [MEM_DATA_W-1:0] mem2proc_data,
  output logic [MEM_TAG_W-1:0]  arb2d_response,
  output logic [MEM_TAG_W-1:0]  arb2i_response,
  output logic [MEM_TAG_W-1:0]  arb2d_tag,
  output logic [MEM_TAG_W-1:0]  arb2i_tag,
  output logic [MEM_DATA_W-1:0] arb2d_data,
  output logic [MEM_DATA_W-1:0] arb2i_data,
  output logic [OUTST_W-1:0]    outstanding,
  output logic                  tag_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  MEM_REQ_t            d_req;
  MEM_REQ_t            i_req;
  MEM_REQ_t            gnt_req;
  logic                d_active;
  logic                i_active;
  logic                gnt_valid;
  logic                accept;
  ARB_OWNER_e          gnt_owner;
  logic                lock_valid;
  ARB_OWNER_e          lock_owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic                cpl_en;
  logic                cpl_hit;
  logic                lookup_valid;
  ARB_OWNER_e          lookup_owner;

  always_comb begin
    d_req    = '{addr: d2arb_addr, data: d2arb_data, command: BUS_COMMAND'(d2arb_command)};
    i_req    = '{addr: i2arb_addr, data: i2arb_data, command: BUS_COMMAND'(i2arb_command)};
    d_active = (d_req.command != BUS_NONE);
    i_active = (i_req.command != BUS_NONE);
    starved  = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  end

  // Lock beats starvation, starvation beats default Dcache priority.
  always_comb begin
    gnt_owner = OWN_DCACHE;
    if (lock_valid && (lock_owner == OWN_ICACHE) && i_active) begin
      gnt_owner = OWN_ICACHE;
    end else if (lock_valid && (lock_owner == OWN_DCACHE) && d_active) begin
      gnt_owner = OWN_DCACHE;
    end else if (!d_active) begin
      gnt_owner = OWN_ICACHE;
    end else if (starved && i_active) begin
      gnt_owner = OWN_ICACHE;
    end
    gnt_valid = d_active || i_active;
    gnt_req   = (gnt_owner == OWN_ICACHE) ? i_req : d_req;
    accept    = gnt_valid && (mem2proc_response != '0);
  end

  always_comb begin
    proc2mem_addr    = gnt_valid ? gnt_req.addr : '0;
    proc2mem_data    = gnt_valid ? gnt_req.data : '0;
    proc2mem_command = gnt_valid ? gnt_req.command : BUS_NONE;
    arb2d_response   = (accept && (gnt_owner == OWN_DCACHE)) ? mem2proc_response : '0;
    arb2i_response   = (accept && (gnt_owner == OWN_ICACHE)) ? mem2proc_response : '0;
  end

  always_comb begin
    cpl_en     = (mem2proc_tag != '0);
    cpl_hit    = cpl_en && lookup_valid;
    arb2d_tag  = (cpl_hit && (lookup_owner == OWN_DCACHE)) ? mem2proc_tag  : '0;
    arb2i_tag  = (cpl_hit && (lookup_owner == OWN_ICACHE)) ? mem2proc_tag  : '0;
    arb2d_data = (cpl_hit && (lookup_owner == OWN_DCACHE)) ? mem2proc_data : '0;
    arb2i_data = (cpl_hit && (lookup_owner == OWN_ICACHE)) ? mem2proc_data : '0;
  end

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (accept && (gnt_req.command == BUS_LOAD)),
    .wr_tag         (mem2proc_response),
    .wr_owner       (gnt_owner),
    .cl_en          (cpl_en),
    .cl_tag         (mem2proc_tag),
    .lookup_valid_c (lookup_valid),
    .lookup_owner_c (lookup_owner),
    .outstanding    (outstanding)
  );

  // Lock follows a rejected grant; starvation counts Dcache wins over a waiting Icache.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lock_valid <= 1'b0;
      lock_owner <= `MEM_ARB_OWNER_RESET;
      starve_cnt <= '0;
      tag_err    <= 1'b0;
    end else begin
      lock_valid <= gnt_valid && !accept;
      if (gnt_valid && !accept) begin
        lock_owner <= gnt_owner;
      end
      if (!i_active || (accept && (gnt_owner == OWN_ICACHE))) begin
        starve_cnt <= '0;
      end else if (accept && (gnt_owner == OWN_DCACHE) && !starved) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
      if (cpl_en && !lookup_valid) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule
